// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the serial chunked adder.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    Idle,
    Busy,
    Done
  } state_e;

  // Slice-index register width; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit full adder used once per slice by the serial adder.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/multicycle_chunk_adder.sv
// WIDTH-bit adder evaluated one CHUNK-bit slice per clock with valid/ready on both sides.
// Define ADDER_SUB_EN to add the sub port (in_1 - in_2 with cout = no-borrow).
module multicycle_chunk_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned IdxW      = idx_width(NumChunks);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_co;

  assign base = 32'(idx_q) * CHUNK;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a  (a_q[base +: CHUNK]),
    .b  (b_q[base +: CHUNK]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      Idle: begin
        if (in_valid) begin
          a_d     = in_1;
          idx_d   = '0;
          sum_d   = '0;
          state_d = Busy;
`ifdef ADDER_SUB_EN
          // Subtraction folds into the add path: invert B once and force carry-in.
          b_d     = sub ? ~in_2 : in_2;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = in_2;
          carry_d = cin;
`endif
        end
      end
      Busy: begin
        sum_d[base +: CHUNK] = slice_sum;
        carry_d              = slice_co;
        if (idx_q == LastIdx) begin
          cout_d  = slice_co;
          state_d = Done;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      Done: begin
        if (out_ready) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == Idle);
  assign out_valid = (state_q == Done);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
